instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential instruction encoder and program loader: the producing end of the opcode interface that the CPU's control decoder consumes. It accepts symbolic instruction commands over a valid/ready handshake, encodes each one into a 32-bit MIPS word for the supported subset (addi, add, lw, sw, bgtz, j), and writes the words to consecutive instruction-memory addresses. It sits between the testbench/boot host and the instruction memory write port, and reports program length, completion, overflow and illegal-command status.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  synchronous restart pulse: clears address, length and status
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_kind  in  3  0 addi, 1 add, 2 lw, 3 sw, 4 bgtz, 5 j, 6–7 illegal
- cmd_rs / cmd_rt / cmd_rd  in  5 each  register fields
- cmd_imm  in  16  immediate / branch offset
- cmd_target  in  26  jump target
- cmd_last  in  1  final instruction of the program
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded instruction
- prog_len  out  ADDR_W+1  number of words written
- done  out  1  program complete (last written, or memory full)
- full  out  1  memory capacity reached
- err_illegal  out  1  sticky: an illegal cmd_kind was accepted

## Operation
- Encodings (op[31:26]):
  - addi: {001000, rs, rt, imm}
  - add: {000000, rs, rt, rd, 00000, 100000}
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - bgtz: {000111, rs, 00000, imm}
  - j: {000010, target}
- FSM states: IDLE, WRITE, DONE.
- cmd_ready = (state == IDLE) && !start.
- IDLE, legal command accepted: register the encoded word, go to WRITE.
- IDLE, illegal command accepted: set err_illegal; nothing is written and the address is unchanged. If cmd_last is set, go to DONE; otherwise stay in IDLE.
- WRITE: imem_we = 1 for exactly one cycle, with the registered address and data. On leaving WRITE, the address and prog_len increment.
  - Go to DONE if cmd_last was set, or if the address just written was 2^ADDR_W−1. The latter also sets full.
  - Otherwise return to IDLE.
- DONE: done = 1 and cmd_ready = 0. Only start or reset leave this state.
- start (any state, including WRITE): next state IDLE; address, prog_len, done, full and err_illegal clear. A pending write in that cycle is suppressed (imem_we forced 0). A simultaneous cmd_valid is not accepted.
- The address never wraps. After full, the block holds in DONE.

## Timing
- Reset (async, rst_n low): state IDLE, imem_we 0, imem_addr 0, imem_wdata 0, prog_len 0, done 0, full 0, err_illegal 0. cmd_ready is 1 once rst_n is high and start is low.
- Accept at edge N. imem_we is high during cycle N+1 with the address and data stable. cmd_ready returns high in cycle N+2.
- Throughput: one instruction per 2 cycles.
- imem_wdata and imem_addr hold their values outside write cycles.
- done, full and prog_len update on the edge that exits WRITE.

## Test plan
- Reset, then addi rs=1 rt=2 imm=5, then add rs=1 rt=2 rd=3 -> writes 0x20220005 @0 and 0x00221820 @1; imem_we is high exactly 2 cycles; prog_len=2.
- lw rs=0 rt=4 imm=8; sw rs=0 rt=4 imm=0xC; bgtz rs=4 imm=0xFFFE; j target=0x10 with cmd_last -> writes 0x8C040008, 0xAC04000C, 0x1C80FFFE, 0x08000010 @0..3; done=1; cmd_ready=0 afterwards.
- Command with cmd_kind=6 between two legal commands -> err_illegal=1 sticky; no write for it; the legal words land at consecutive addresses 0 and 1.
- ADDR_W=2: send 5 commands, none with cmd_last -> 4 writes @0..3; full=1 and done=1 after the 4th; the 5th is never accepted; prog_len=4.
- start asserted in the WRITE cycle together with cmd_valid -> no write that cycle; next cycle IDLE with addr 0 and all status clear; the command is accepted on the following cycle.
- rst_n pulled low mid-program (in WRITE) -> imem_we drops immediately and all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder
//   Encodes symbolic instruction commands (addi, add, lw, sw, bgtz, j) into
//   32-bit MIPS words. It writes each word to the next consecutive
//   instruction-memory address.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             synchronous restart: clears address, length and status
//   cmd_valid/ready   command handshake; accepted when both are high
//   cmd_kind          0 addi, 1 add, 2 lw, 3 sw, 4 bgtz, 5 j, 6-7 illegal
//   cmd_rs/rt/rd      register fields
//   cmd_imm           immediate / branch offset
//   cmd_target        jump target
//   cmd_last          final instruction of the program
//   imem_we           one-cycle instruction-memory write strobe
//   imem_addr         write word address (holds its value between writes)
//   imem_wdata        encoded instruction (holds its value between writes)
//   prog_len          number of words written
//   done              program complete (last word written, or memory full)
//   full              memory capacity reached
//   err_illegal       sticky flag: an illegal cmd_kind was accepted
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_kind,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   prog_len,
  output logic              done,
  output logic              full,
  output logic              err_illegal
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;    // next address to be written
  logic [ADDR_W-1:0] r_waddr;  // address presented on imem_addr
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_len;
  logic              r_full;
  logic              r_err;
  logic              r_last;
  logic              w_accept;
  logic              w_legal;
  logic              w_at_top;

  function automatic logic [31:0] encode(
    input logic [2:0]  kind,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [31:0] word;
    case (kind)
      3'd0:    word = {6'b001000, rs, rt, imm};
      3'd1:    word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      3'd2:    word = {6'b100011, rs, rt, imm};
      3'd3:    word = {6'b101011, rs, rt, imm};
      3'd4:    word = {6'b000111, rs, 5'b00000, imm};
      3'd5:    word = {6'b000010, target};
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  assign cmd_ready = (r_state == IDLE) && !start;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_legal   = (cmd_kind <= 3'd5);
  // The address never wraps: writing the top word ends the program.
  assign w_at_top  = (r_ptr == {ADDR_W{1'b1}});

  // A restart in the WRITE cycle suppresses the pending write.
  assign imem_we     = (r_state == WRITE) && !start;
  assign imem_addr   = r_waddr;
  assign imem_wdata  = r_wdata;
  assign prog_len    = r_len;
  assign done        = (r_state == DONE);
  assign full        = r_full;
  assign err_illegal = r_err;

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_legal)       w_next = WRITE;
            else if (cmd_last) w_next = DONE;
          end
        end
        WRITE:   w_next = (r_last || w_at_top) ? DONE : IDLE;
        DONE:    w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_len   <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
    end else if (start) begin
      r_ptr   <= '0;
      r_waddr <= '0;
      r_len   <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (w_legal) begin
          r_wdata <= encode(cmd_kind, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target);
          r_waddr <= r_ptr;
          r_last  <= cmd_last;
        end else begin
          r_err   <= 1'b1;
        end
      end
      if (r_state == WRITE) begin
        r_len <= r_len + 1'b1;
        if (w_at_top) r_full <= 1'b1;
        else          r_ptr  <= r_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder.
//   Instance dut uses ADDR_W=8. Instance dut2 uses ADDR_W=2 for the capacity case.
//   Inputs are driven 1 time unit after the rising edge.
//   Outputs are sampled on the falling edge, or 1 time unit after the rising edge.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cmd_valid, cmd_valid2;
  logic [2:0]  cmd_kind;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic        cmd_last;

  logic        cmd_ready, imem_we, done, full, err_illegal;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  prog_len;

  logic        cmd_ready2, imem_we2, done2, full2, err_illegal2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  prog_len2;

  int n_checks = 0;
  int n_err    = 0;
  int we_cnt   = 0;
  logic [7:0]  q_addr[$];
  logic [31:0] q_data[$];
  logic [1:0]  q2_addr[$];
  logic [31:0] q2_data[$];
  bit acc;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .prog_len(prog_len), .done(done), .full(full), .err_illegal(err_illegal)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
    .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
    .prog_len(prog_len2), .done(done2), .full(full2), .err_illegal(err_illegal2)
  );

  // Write monitor: record every strobed write.
  always @(negedge clk) begin
    if (imem_we) begin
      q_addr.push_back(imem_addr);
      q_data.push_back(imem_wdata);
      we_cnt++;
    end
    if (imem_we2) begin
      q2_addr.push_back(imem_addr2);
      q2_data.push_back(imem_wdata2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    q_addr.delete(); q_data.delete(); q2_addr.delete(); q2_data.delete();
    we_cnt = 0;
  endtask

  // Called 1 time unit after a rising edge. Returns 1 time unit after the accepting edge.
  task automatic send(input bit which, input logic [2:0] k, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last, input int budget,
                      output bit accepted);
    bit rdy;
    accepted   = 1'b0;
    cmd_kind   = k;  cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_imm    = imm; cmd_target = tgt; cmd_last = last;
    if (which) cmd_valid2 = 1'b1; else cmd_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      rdy = which ? cmd_ready2 : cmd_ready;
      @(posedge clk); #1;
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    cmd_kind = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
    cmd_imm = '0; cmd_target = '0; cmd_last = 1'b0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", {24'd0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_len", {23'd0, prog_len}, 32'd0);
    check("rst_flags", {29'd0, done, full, err_illegal}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    clear_logs();

    // addi then add, including handshake timing
    send(0, 3'd0, 5'd1, 5'd2, 5'd0, 16'd5, 26'd0, 1'b0, 20, acc);
    check("t1_acc0", {31'd0, acc}, 32'd1);
    @(negedge clk);
    check("t1_we_n1", {31'd0, imem_we}, 32'd1);
    check("t1_rdy_n1", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("t1_we_n2", {31'd0, imem_we}, 32'd0);
    check("t1_rdy_n2", {31'd0, cmd_ready}, 32'd1);
    check("t1_hold_addr", {24'd0, imem_addr}, 32'd0);
    check("t1_hold_data", imem_wdata, 32'h2022_0005);
    @(posedge clk); #1;
    send(0, 3'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 20, acc);
    check("t1_acc1", {31'd0, acc}, 32'd1);
    idle_cycles(3);
    check("t1_nwr", 32'(q_data.size()), 32'd2);
    if (q_data.size() == 2) begin
      check("t1_a0", {24'd0, q_addr[0]}, 32'd0);
      check("t1_d0", q_data[0], 32'h2022_0005);
      check("t1_a1", {24'd0, q_addr[1]}, 32'd1);
      check("t1_d1", q_data[1], 32'h0022_1820);
    end
    check("t1_wecnt", 32'(we_cnt), 32'd2);
    check("t1_len", {23'd0, prog_len}, 32'd2);

    // lw, sw, bgtz, j(last)
    pulse_start();
    check("t2_len_clr", {23'd0, prog_len}, 32'd0);
    clear_logs();
    send(0, 3'd2, 5'd0, 5'd4, 5'd0, 16'h0008, 26'd0, 1'b0, 20, acc);
    check("t2_acc0", {31'd0, acc}, 32'd1);
    send(0, 3'd3, 5'd0, 5'd4, 5'd0, 16'h000C, 26'd0, 1'b0, 20, acc);
    check("t2_acc1", {31'd0, acc}, 32'd1);
    send(0, 3'd4, 5'd4, 5'd0, 5'd0, 16'hFFFE, 26'd0, 1'b0, 20, acc);
    check("t2_acc2", {31'd0, acc}, 32'd1);
    send(0, 3'd5, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10, 1'b1, 20, acc);
    check("t2_acc3", {31'd0, acc}, 32'd1);
    idle_cycles(1);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_full", {31'd0, full}, 32'd0);
    check("t2_len", {23'd0, prog_len}, 32'd4);
    idle_cycles(3);
    check("t2_rdy", {31'd0, cmd_ready}, 32'd0);
    check("t2_done_hold", {31'd0, done}, 32'd1);
    check("t2_nwr", 32'(q_data.size()), 32'd4);
    if (q_data.size() == 4) begin
      check("t2_d0", q_data[0], 32'h8C04_0008);
      check("t2_d1", q_data[1], 32'hAC04_000C);
      check("t2_d2", q_data[2], 32'h1C80_FFFE);
      check("t2_d3", q_data[3], 32'h0800_0010);
      check("t2_a3", {24'd0, q_addr[3]}, 32'd3);
    end

    // Illegal command between two legal ones
    pulse_start();
    check("t3_done_clr", {31'd0, done}, 32'd0);
    clear_logs();
    send(0, 3'd0, 5'd1, 5'd2, 5'd0, 16'd5, 26'd0, 1'b0, 20, acc);
    check("t3_acc0", {31'd0, acc}, 32'd1);
    send(0, 3'd6, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'd0, 1'b0, 20, acc);
    check("t3_acc_ill", {31'd0, acc}, 32'd1);
    idle_cycles(1);
    check("t3_err", {31'd0, err_illegal}, 32'd1);
    send(0, 3'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, 20, acc);
    check("t3_acc1", {31'd0, acc}, 32'd1);
    idle_cycles(2);
    check("t3_err_sticky", {31'd0, err_illegal}, 32'd1);
    check("t3_nwr", 32'(q_data.size()), 32'd2);
    if (q_data.size() == 2) begin
      check("t3_a0", {24'd0, q_addr[0]}, 32'd0);
      check("t3_a1", {24'd0, q_addr[1]}, 32'd1);
      check("t3_d1", q_data[1], 32'h0022_1820);
    end
    check("t3_len", {23'd0, prog_len}, 32'd2);

    // Capacity limit on the ADDR_W=2 instance
    pulse_start();
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      send(1, 3'd0, 5'd1, 5'd2, 5'd0, 16'(i), 26'd0, 1'b0, 20, acc);
      check("t4_acc", {31'd0, acc}, 32'd1);
    end
    idle_cycles(1);
    check("t4_full", {31'd0, full2}, 32'd1);
    check("t4_done", {31'd0, done2}, 32'd1);
    send(1, 3'd0, 5'd1, 5'd2, 5'd0, 16'd4, 26'd0, 1'b0, 8, acc);
    check("t4_acc5_refused", {31'd0, acc}, 32'd0);
    check("t4_len", {29'd0, prog_len2}, 32'd4);
    check("t4_nwr", 32'(q2_data.size()), 32'd4);
    if (q2_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t4_addr", {30'd0, q2_addr[i]}, 32'(i));
        check("t4_data", q2_data[i], 32'h2022_0000 | 32'(i));
      end
    end

    // start during WRITE with a simultaneous command
    pulse_start();
    send(0, 3'd6, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0, 20, acc);
    check("t5_acc_ill", {31'd0, acc}, 32'd1);
    send(0, 3'd0, 5'd1, 5'd2, 5'd0, 16'd5, 26'd0, 1'b0, 20, acc);
    check("t5_acc0", {31'd0, acc}, 32'd1);
    clear_logs();
    start = 1'b1;
    cmd_valid = 1'b1; cmd_kind = 3'd1; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd3;
    @(negedge clk);
    check("t5_we_supp", {31'd0, imem_we}, 32'd0);
    check("t5_rdy_supp", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("t5_addr_clr", {24'd0, imem_addr}, 32'd0);
    check("t5_status_clr", {23'd0, prog_len, done, full, err_illegal}, 32'd0);
    check("t5_rdy", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t5_we", {31'd0, imem_we}, 32'd1);
    check("t5_wdata", imem_wdata, 32'h0022_1820);
    idle_cycles(2);
    check("t5_nwr", 32'(q_data.size()), 32'd1);
    if (q_data.size() == 1) check("t5_a0", {24'd0, q_addr[0]}, 32'd0);
    check("t5_len", {23'd0, prog_len}, 32'd1);

    // Asynchronous reset during WRITE
    send(0, 3'd7, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0, 20, acc);
    check("t6_acc_ill", {31'd0, acc}, 32'd1);
    send(0, 3'd2, 5'd0, 5'd4, 5'd0, 16'h0008, 26'd0, 1'b0, 20, acc);
    check("t6_acc", {31'd0, acc}, 32'd1);
    check("t6_we_pre", {31'd0, imem_we}, 32'd1);
    check("t6_err_pre", {31'd0, err_illegal}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_we", {31'd0, imem_we}, 32'd0);
    check("t6_addr", {24'd0, imem_addr}, 32'd0);
    check("t6_wdata", imem_wdata, 32'd0);
    check("t6_len", {23'd0, prog_len}, 32'd0);
    check("t6_flags", {29'd0, done, full, err_illegal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_rdy", {31'd0, cmd_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
